// File: rtl/mem_pkg.sv
// Shared definitions for the DDR2 burst front end and the DAQ readout blocks.
// Holds the FSM state encoding, default bus widths and the burst-length check.
package mem_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 25;
  localparam int DEF_SIZE_W    = 3;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_TIMEOUT   = 1023;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    WR_BURST = 3'd2,
    RD_REQ   = 3'd3,
    RD_WAIT  = 3'd4
  } mem_state_e;

  // A burst must move at least one beat and no more than the port supports.
  function automatic logic len_legal(input int len, input int max_burst);
    return (len >= 1) && (len <= max_burst);
  endfunction

endpackage

// File: rtl/mem_burst_port_if.sv
// Client and controller-side signals of mem_burst_port.
//   slave  : the burst port itself (accepts commands, drives local_* requests)
//   master : the environment (client + DDR2 controller local interface)
interface mem_burst_port_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SIZE_W = DEF_SIZE_W
);
  // client command / data stream
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [SIZE_W-1:0]     cmd_len;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  cmd_err;
  logic                  timeout_err;
  // DDR2 controller local interface
  logic [ADDR_W-1:0]     local_address;
  logic                  local_write_req;
  logic                  local_read_req;
  logic                  local_burstbegin;
  logic [SIZE_W-1:0]     local_size;
  logic [DATA_W-1:0]     local_wdata;
  logic [DATA_W/8-1:0]   local_be;
  logic                  local_ready;
  logic [DATA_W-1:0]     local_rdata;
  logic                  local_rdata_valid;
  logic                  local_init_done;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
           local_ready, local_rdata, local_rdata_valid, local_init_done,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, cmd_err, timeout_err,
           local_address, local_write_req, local_read_req, local_burstbegin,
           local_size, local_wdata, local_be
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
           local_ready, local_rdata, local_rdata_valid, local_init_done,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, cmd_err, timeout_err,
           local_address, local_write_req, local_read_req, local_burstbegin,
           local_size, local_wdata, local_be
  );

endinterface

// File: rtl/mem_watchdog.sv
// Read-return watchdog.
//   phy_clk, reset : clock, async active-high reset
//   enable         : count while high
//   clear          : restart the count (takes priority over enable)
//   expired        : high on the TIMEOUT-th consecutive enabled, uncleared cycle
module mem_watchdog
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic phy_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Combinational so the owner can act on the very cycle the limit is hit;
  // the counter restarts on expiry so the pulse is one cycle wide.
  assign expired = enable && !clear && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (clear || expired) cnt <= '0;
    else if (enable)           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_burst_port.sv
// Burst front end between a client command/data stream and the DDR2
// controller local interface, all in the phy_clk domain.
//   phy_clk, reset : clock, async active-high reset
//   bus (slave)    : client side  cmd_* / wr_* / rd_* / busy / cmd_err / timeout_err
//                    controller   local_* requests, write data, read return
// One command in flight at a time. Writes stream straight through to the
// controller; reads are returned one cycle after local_rdata_valid.
module mem_burst_port
  import mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SIZE_W    = DEF_SIZE_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              phy_clk,
  input  logic              reset,
  mem_burst_port_if.slave   bus
);
  localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

  mem_state_e           state;
  logic [ADDR_W-1:0]    addr_q;
  logic [SIZE_W-1:0]    len_q;
  logic [SIZE_W-1:0]    beat_cnt;
  logic [DATA_W-1:0]    rd_data_q;
  logic                 rd_valid_q;
  logic                 cmd_err_q;
  logic                 timeout_err_q;
  logic                 cmd_ready_q;
  logic                 busy_q;
  logic                 wd_expired;
  logic                 last_beat;
  logic                 len_ok;
  logic                 in_wr;
  logic                 in_rdreq;
  logic                 in_rdwait;

  assign in_wr     = (state == WR_BURST);
  assign in_rdreq  = (state == RD_REQ);
  assign in_rdwait = (state == RD_WAIT);
  assign last_beat = (beat_cnt + ONE) == len_q;
  assign len_ok    = len_legal(int'(bus.cmd_len), MAX_BURST);

  // Idle cycles only count while waiting for read data; any beat restarts it.
  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .phy_clk (phy_clk),
    .reset   (reset),
    .clear   (!in_rdwait || bus.local_rdata_valid),
    .enable  (in_rdwait),
    .expired (wd_expired)
  );

  // cmd_ready/busy are registered alongside the state so reset can hold
  // them at 0; busy rises on the first edge after reset while still in INIT.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state         <= INIT;
      addr_q        <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rd_valid_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state)
        INIT: begin
          busy_q      <= 1'b1;
          cmd_ready_q <= 1'b0;
          if (bus.local_init_done) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        IDLE: begin
          // A command already handshaken is honoured even if init_done drops.
          if (bus.cmd_valid) begin
            addr_q   <= bus.cmd_addr;
            len_q    <= bus.cmd_len;
            beat_cnt <= '0;
            if (!len_ok) begin
              cmd_err_q <= 1'b1;
            end else begin
              state       <= bus.cmd_write ? WR_BURST : RD_REQ;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end else if (!bus.local_init_done) begin
            state       <= INIT;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        WR_BURST: begin
          if (bus.wr_valid && bus.local_ready) begin
            beat_cnt <= beat_cnt + ONE;
            if (last_beat) begin
              state       <= IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        RD_REQ: begin
          if (bus.local_ready) begin
            state    <= RD_WAIT;
            beat_cnt <= '0;
          end
        end
        RD_WAIT: begin
          if (wd_expired) begin
            timeout_err_q <= 1'b1;
            state         <= IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
          end else if (bus.local_rdata_valid) begin
            rd_data_q  <= bus.local_rdata;
            rd_valid_q <= 1'b1;
            beat_cnt   <= beat_cnt + ONE;
            if (last_beat) begin
              state       <= IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        default: begin
          state       <= INIT;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.timeout_err = timeout_err_q;

  // Write beats pass straight through; the controller's ready is the backpressure.
  assign bus.wr_ready         = in_wr && bus.local_ready;
  assign bus.local_write_req  = in_wr && bus.wr_valid;
  assign bus.local_wdata      = in_wr ? bus.wr_data : '0;
  assign bus.local_read_req   = in_rdreq;
  assign bus.local_burstbegin = in_rdreq || (in_wr && bus.wr_valid && (beat_cnt == '0));
  assign bus.local_address    = (in_wr || in_rdreq || in_rdwait) ? addr_q : '0;
  assign bus.local_size       = (in_wr || in_rdreq || in_rdwait) ? len_q  : '0;
  assign bus.local_be         = '1;

endmodule

// File: tb/tb_mem_burst_port.sv
module tb_mem_burst_port;
  localparam int DATA_W = 32, ADDR_W = 25, SIZE_W = 3, MAX_BURST = 4, TIMEOUT = 1023;
  localparam int EV_WR = 0, EV_RQ = 1, EV_RD = 2, EV_CERR = 3, EV_TERR = 4;

  typedef struct {
    int                kind;
    logic [31:0]       data;
    logic [24:0]       addr;
    logic [2:0]        size;
    logic              bb;
  } ev_t;

  logic phy_clk = 1'b0;
  logic reset;
  int   n_pass = 0, n_total = 0;
  ev_t  exp_q[$];
  logic prev_rdv = 1'b0;

  mem_burst_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

  mem_burst_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
    .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .phy_clk (phy_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic [24:0] a,
                      input logic [2:0] s, input logic bb);
    ev_t e;
    e.kind = k; e.data = d; e.addr = a; e.size = s; e.bb = bb;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge phy_clk); #1;
  endtask

  function automatic logic [127:0] outs();
    return 128'({bus.cmd_ready, bus.wr_ready, bus.rd_data, bus.rd_valid, bus.busy,
                 bus.cmd_err, bus.timeout_err, bus.local_address, bus.local_write_req,
                 bus.local_read_req, bus.local_burstbegin, bus.local_size, bus.local_wdata});
  endfunction

  // Monitor: every observable DUT event consumes the next expected entry.
  task automatic take(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 128'(k), 128'(e.kind));
    case (k)
      EV_WR: begin
        chk("wr_addr", 128'(bus.local_address), 128'(e.addr));
        chk("wr_size", 128'(bus.local_size), 128'(e.size));
        chk("wr_data", 128'(bus.local_wdata), 128'(e.data));
        chk("wr_burstbegin", 128'(bus.local_burstbegin), 128'(e.bb));
        chk("wr_ready", 128'(bus.wr_ready), 128'(1));
      end
      EV_RQ: begin
        chk("rq_addr", 128'(bus.local_address), 128'(e.addr));
        chk("rq_size", 128'(bus.local_size), 128'(e.size));
        chk("rq_burstbegin", 128'(bus.local_burstbegin), 128'(e.bb));
      end
      EV_RD: begin
        chk("rd_data", 128'(bus.rd_data), 128'(e.data));
        chk("rd_latency", 128'(prev_rdv), 128'(1));
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge phy_clk);
      if (bus.local_write_req && bus.local_ready) take(EV_WR);
      if (bus.local_read_req && bus.local_ready)  take(EV_RQ);
      if (bus.rd_valid)    take(EV_RD);
      if (bus.cmd_err)     take(EV_CERR);
      if (bus.timeout_err) take(EV_TERR);
      prev_rdv = bus.local_rdata_valid;
    end
  end

  task automatic send_cmd(input logic wr, input logic [24:0] a, input logic [2:0] len);
    logic ok = 1'b0;
    tick();
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = len;
    for (int i = 0; i < 50; i++) begin
      @(negedge phy_clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_accept", 128'(ok), 128'(1));
    @(posedge phy_clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic seen;
    int   n;
    reset = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_data = '0; bus.wr_valid = 0; bus.local_ready = 0; bus.local_rdata = '0;
    bus.local_rdata_valid = 0; bus.local_init_done = 0;

    // reset state
    #3;
    chk("reset_outputs", outs(), 128'(0));
    chk("reset_be", 128'(bus.local_be), 128'(4'hF));
    tick();
    reset = 1'b0;

    // controller still initialising for 20 cycles
    seen = 1'b0;
    repeat (20) begin
      tick();
      @(negedge phy_clk);
      seen = seen | bus.cmd_ready;
    end
    chk("init_hold_cmd_ready", 128'(seen), 128'(0));
    chk("init_busy", 128'(bus.busy), 128'(1));
    tick();
    bus.local_init_done = 1'b1;
    @(negedge phy_clk);
    chk("init_rise_cmd_ready", 128'(bus.cmd_ready), 128'(0));
    @(negedge phy_clk);
    chk("init_done_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    chk("idle_busy", 128'(bus.busy), 128'(0));
    bus.local_ready = 1'b1;

    // write burst, len 4, controller stalls 3 cycles on beat 2, client gap before beat 3
    send_cmd(1'b1, 25'h0000100, 3'd4);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin bus.wr_valid = 1'b0; tick(); end
      bus.wr_data = 32'hA0 + i; bus.wr_valid = 1'b1;
      push(EV_WR, 32'hA0 + i, 25'h100, 3'd4, i == 0);
      if (i == 2) begin bus.local_ready = 1'b0; repeat (3) tick(); bus.local_ready = 1'b1; end
      tick();
    end
    bus.wr_valid = 1'b0;
    @(negedge phy_clk);
    chk("wr_done_busy", 128'(bus.busy), 128'(0));
    chk("wr_done_cmd_ready", 128'(bus.cmd_ready), 128'(1));

    // read burst, len 4, beat gaps 0/2/5
    push(EV_RQ, 0, 25'h100, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) push(EV_RD, 32'hA0 + i, 0, 0, 0);
    send_cmd(1'b0, 25'h0000100, 3'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.local_rdata = 32'hA0 + i; bus.local_rdata_valid = 1'b1;
      tick();
      bus.local_rdata_valid = 1'b0;
      if (i == 1) repeat (2) tick();
      if (i == 2) repeat (5) tick();
    end
    tick();
    @(negedge phy_clk);
    chk("rd_done_busy", 128'(bus.busy), 128'(0));

    // illegal lengths
    push(EV_CERR, 0, 0, 0, 0);
    send_cmd(1'b0, 25'h55, 3'd0);
    push(EV_CERR, 0, 0, 0, 0);
    send_cmd(1'b1, 25'h55, 3'd5);
    repeat (3) tick();
    @(negedge phy_clk);
    chk("err_idle_busy", 128'(bus.busy), 128'(0));
    chk("err_idle_cmd_ready", 128'(bus.cmd_ready), 128'(1));

    // read len 2, one beat then silence
    push(EV_RQ, 0, 25'h200, 3'd2, 1'b1);
    push(EV_RD, 32'h5A, 0, 0, 0);
    push(EV_TERR, 0, 0, 0, 0);
    send_cmd(1'b0, 25'h200, 3'd2);
    tick();
    bus.local_rdata = 32'h5A; bus.local_rdata_valid = 1'b1;
    @(posedge phy_clk); #1;
    bus.local_rdata_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < TIMEOUT + 50) begin
      @(posedge phy_clk);
      n++;
      @(negedge phy_clk);
      seen = bus.timeout_err;
    end
    chk("timeout_seen", 128'(seen), 128'(1));
    chk("timeout_cycles", 128'(n), 128'(TIMEOUT));
    chk("timeout_busy", 128'(bus.busy), 128'(0));
    tick();
    bus.local_rdata = 32'hDEAD; bus.local_rdata_valid = 1'b1;
    tick();
    bus.local_rdata_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge phy_clk); seen = seen | bus.rd_valid; end
    chk("stray_rd_valid", 128'(seen), 128'(0));

    // async reset in the middle of a write burst
    push(EV_WR, 32'hC0, 25'h300, 3'd4, 1'b1);
    push(EV_WR, 32'hC1, 25'h300, 3'd4, 1'b0);
    send_cmd(1'b1, 25'h300, 3'd4);
    for (int i = 0; i < 2; i++) begin
      bus.wr_data = 32'hC0 + i; bus.wr_valid = 1'b1;
      tick();
    end
    bus.wr_data = 32'hC2;
    #2 reset = 1'b1;
    #1;
    chk("midburst_reset_outputs", outs(), 128'(0));
    chk("midburst_reset_be", 128'(bus.local_be), 128'(4'hF));
    @(posedge phy_clk); #1;
    reset = 1'b0; bus.wr_valid = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge phy_clk); seen = seen | bus.cmd_err | bus.timeout_err; end
    chk("reset_no_err_pulse", 128'(seen), 128'(0));
    chk("reset_back_idle", 128'(bus.cmd_ready), 128'(1));

    repeat (3) tick();
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_burst_port.md
Name: mem_burst_port

Overview:
Parametrised successor to the single-word DDR2 memory front end. It connects a client command/data stream to the DDR2 controller local interface. It adds multi-beat bursts (1..MAX_BURST), streamed write data with backpressure, in-order read return, length checking and a read watchdog. It sits between the DAQ data path and the DDR2 controller and runs entirely in the controller's phy_clk domain.

Parameters:
DATA_W, 32, local data width in bits; must be a multiple of 8
ADDR_W, 25, local word address width
SIZE_W, 3, width of cmd_len and local_size
MAX_BURST, 4, largest legal burst length; must be ≤ 2^SIZE_W-1
TIMEOUT, 1023, idle cycles allowed between read beats before abort

Ports:
phy_clk  in  1  clock; all logic is rising-edge
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  first word address
cmd_len  in  SIZE_W  beats, 1..MAX_BURST
wr_data  in  DATA_W  write beat
wr_valid  in  1  write beat present
wr_ready  out  1  beat consumed when wr_valid&wr_ready
rd_data  out  DATA_W  read beat (registered)
rd_valid  out  1  read beat strobe; no backpressure
busy  out  1  high outside IDLE
cmd_err  out  1  one-cycle pulse on an illegal cmd_len
timeout_err  out  1  one-cycle pulse on read watchdog expiry
local_address  out  ADDR_W  to controller
local_write_req  out  1  to controller
local_read_req  out  1  to controller
local_burstbegin  out  1  to controller
local_size  out  SIZE_W  to controller
local_wdata  out  DATA_W  to controller
local_be  out  DATA_W/8  byte enables; all ones
local_ready  in  1  from controller
local_rdata  in  DATA_W  from controller
local_rdata_valid  in  1  from controller
local_init_done  in  1  from controller

Behaviour:
- Clock phy_clk. Reset is asynchronous and active-high. Reset forces state INIT, clears all counters, and drives every output to 0 except local_be (all ones). A reset mid-burst abandons the burst; no completion or error pulse is generated.
- States: INIT, IDLE, WR_BURST, RD_REQ, RD_WAIT.
- INIT: cmd_ready=0, busy=1. Move to IDLE on the first cycle with local_init_done=1.
- IDLE: cmd_ready=1, busy=0. If local_init_done=0, go to INIT.
- On command handshake, register addr, len and write. A legal len is 1..MAX_BURST.
  - Illegal len (0 or >MAX_BURST): pulse cmd_err next cycle and stay in IDLE.
  - Legal write: go to WR_BURST. Legal read: go to RD_REQ.
- WR_BURST: combinational pass-through.
  - local_write_req=wr_valid, local_wdata=wr_data, wr_ready=local_ready.
  - local_address and local_size come from registered values.
  - local_burstbegin=wr_valid only while beat count=0.
  - A beat transfers on wr_valid&local_ready. After the len-th beat, return to IDLE on the next cycle.
  - wr_valid low is a legal stall; requests hold while local_ready=0.
  - wr_ready=0 in all other states.
- RD_REQ: local_read_req=1, local_burstbegin=1, local_size=len. Hold until local_ready=1, then go to RD_WAIT.
- RD_WAIT:
  - Each local_rdata_valid registers local_rdata into rd_data, pulses rd_valid one cycle later, and increments the beat count. Latency is 1 cycle.
  - After the len-th beat, go to IDLE.
  - The watchdog counts cycles without local_rdata_valid and clears on each beat. When it reaches TIMEOUT, pulse timeout_err, go to IDLE, and deliver no further beats.
- local_rdata_valid outside RD_WAIT (stray or late beats) is ignored; rd_valid stays 0.
- Beat counter width is SIZE_W. No address increment is done here; the controller bursts from local_address.
- Only one command is outstanding at a time; cmd_ready=0 until the state returns to IDLE.
- cmd_err and timeout_err are never asserted together.

Decomposition:
- Package mem_pkg: state encoding constants (INIT..RD_WAIT) and default widths DATA_W/ADDR_W/SIZE_W, shared with the DAQ readout blocks.
- One sub-module, mem_watchdog, holds the parametrised TIMEOUT counter. Inputs: clear, enable. Output: one-cycle expired pulse.

Test Plan:
- Hold local_init_done=0 for 20 cycles, then raise it → cmd_ready stays 0 until 1 cycle after the rise.
- Write, addr=0x0000100, len=4, beats 0xA0..0xA3, local_ready dropping for 3 cycles on beat 2 → exactly 4 local_write_req transfers, burstbegin only on beat 0, local_size=4, then IDLE.
- Read, addr=0x0000100, len=4, controller returns 4 beats with gaps of 0/2/5 cycles → rd_valid 4 times, data 0xA0..0xA3, each 1 cycle after local_rdata_valid, busy low afterward.
- cmd_len=0, then cmd_len=5 (MAX_BURST=4) → cmd_err pulses twice, no local_* requests, state stays IDLE.
- Read, len=2, controller returns 1 beat then silence → timeout_err once TIMEOUT=1023 idle cycles have elapsed; a later stray local_rdata_valid produces no rd_valid.
- Assert reset asynchronously mid write burst after beat 1 → all outputs 0 immediately, state INIT, no cmd_err or timeout_err pulse.
